// File: rtl/cam_frame_writer.sv
// Frame-buffer writer: converts the RGB888 pixel stream to RGB332 and writes it linearly
// into a single-port frame RAM, aligned to frame boundaries, with frame length checks.
module cam_frame_writer #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              p_clock,
  input  logic              rst,
  input  logic              enable,
  input  logic [23:0]       pixel_data,
  input  logic              pixel_valid,
  input  logic              frame_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              frame_ready,
  output logic [ADDR_W:0]   frame_pixels,
  output logic              err_overflow,
  output logic              err_short,
  output logic              busy
);

  localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W+1)'(H_RES * V_RES);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;
  logic              fd_prev_q;

  logic [ADDR_W-1:0] mem_addr_d;
  logic [7:0]        mem_data_d;
  logic              mem_we_d, frame_ready_d, err_overflow_d, err_short_d;
  logic [ADDR_W:0]   frame_pixels_d;

  logic              fd_rise, pix_ok;
  logic [ADDR_W:0]   cnt_inc;
  logic [7:0]        rgb332;
  logic              unused_pix;

  assign rgb332     = {pixel_data[7:5], pixel_data[15:13], pixel_data[23:22]};
  assign unused_pix = ^{pixel_data[4:0], pixel_data[12:8], pixel_data[21:16]};
  assign fd_rise    = frame_done & ~fd_prev_q;
  // The counter saturates at FRAME_PIX, so the address never wraps.
  assign pix_ok     = pixel_valid && (wr_cnt_q < FRAME_PIX);
  assign cnt_inc    = wr_cnt_q + {{ADDR_W{1'b0}}, pix_ok};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    mem_addr_d     = mem_addr;
    mem_data_d     = mem_data;
    mem_we_d       = 1'b0;
    frame_ready_d  = 1'b0;
    frame_pixels_d = frame_pixels;
    err_overflow_d = err_overflow;
    err_short_d    = err_short;

    if (!enable) begin
      state_d  = IDLE;
      wr_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_cnt_d = '0;
          state_d  = SYNC;
        end
        SYNC: begin
          // Wait for a frame boundary so address 0 always holds a frame's first pixel.
          if (frame_done) begin
            state_d  = CAPTURE;
            wr_cnt_d = '0;
          end
        end
        CAPTURE: begin
          if (pixel_valid) begin
            if (pix_ok) begin
              mem_we_d   = 1'b1;
              mem_addr_d = wr_cnt_q[ADDR_W-1:0];
              mem_data_d = rgb332;
            end else begin
              err_overflow_d = 1'b1;
            end
          end
          wr_cnt_d = cnt_inc;
          // A pixel arriving with the closing strobe still belongs to the closing frame.
          if (fd_rise) begin
            frame_pixels_d = cnt_inc;
            frame_ready_d  = (cnt_inc == FRAME_PIX);
            err_short_d    = (cnt_inc < FRAME_PIX);
            wr_cnt_d       = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge p_clock) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_cnt_q     <= '0;
      fd_prev_q    <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_we       <= 1'b0;
      frame_ready  <= 1'b0;
      frame_pixels <= '0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      fd_prev_q    <= frame_done;
      mem_addr     <= mem_addr_d;
      mem_data     <= mem_data_d;
      mem_we       <= mem_we_d;
      frame_ready  <= frame_ready_d;
      frame_pixels <= frame_pixels_d;
      err_overflow <= err_overflow_d;
      err_short    <= err_short_d;
      busy         <= (state_d == CAPTURE);
    end
  end

endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Downstream stage of the camera capture block: takes the 24-bit RGB pixel stream (`pixel_data`/`pixel_valid`/`frame_done`), reduces each pixel to RGB332 and writes it into a single-port frame-buffer RAM at a linearly incrementing address. It aligns writing to frame boundaries, reports completed frames to the display/readout side, and flags frames that are too long or too short for the buffer.

## Interface
Parameters:
- `H_RES`, 160, active pixels per line
- `V_RES`, 120, lines per frame
- `ADDR_W`, 15, buffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES

Ports:
- `p_clock` in 1: pixel clock, sole clock, all logic on rising edge
- `rst` in 1: reset, synchronous, active-low
- `enable` in 1: run; low returns block to IDLE
- `pixel_data` in 24: [7:0]=R, [15:8]=G, [23:16]=B
- `pixel_valid` in 1: `pixel_data` valid this cycle
- `frame_done` in 1: end-of-frame strobe from capture stage
- `mem_addr` out ADDR_W: buffer write address
- `mem_data` out 8: RGB332 = {R[7:5], G[7:5], B[7:6]}
- `mem_we` out 1: buffer write strobe
- `frame_ready` out 1: one-cycle pulse, a complete buffer frame was written
- `frame_pixels` out ADDR_W+1: pixel count of last closed frame
- `err_overflow` out 1: sticky, pixels arrived beyond H_RES*V_RES
- `err_short` out 1: last closed frame had fewer than H_RES*V_RES pixels
- `busy` out 1: high in CAPTURE

## Operation
- Constant FRAME_PIX = H_RES*V_RES. Internal counter `wr_cnt`, ADDR_W+1 bits.
- States: IDLE, SYNC, CAPTURE.
  - IDLE: `mem_we`=0, `wr_cnt`=0. `enable`=1 → SYNC.
  - SYNC: ignore pixels (no writes) until `frame_done`=1 → CAPTURE, `wr_cnt`=0. Guarantees address 0 = first pixel of a frame.
  - CAPTURE: each cycle with `pixel_valid`=1: if `wr_cnt` < FRAME_PIX, write `mem_addr`=`wr_cnt`, `mem_data`=RGB332, `wr_cnt`++; else drop pixel, set `err_overflow`.
  - CAPTURE + `frame_done`=1: `frame_pixels`←final count (including any pixel written same cycle), `frame_ready` pulse only if count = FRAME_PIX; `err_short`←(count < FRAME_PIX); `wr_cnt`←0; stay CAPTURE.
  - `enable`=0 in any state → IDLE next cycle; partial frame discarded, no `frame_ready`, `frame_pixels` unchanged.
- Simultaneous `pixel_valid` and `frame_done`: pixel belongs to the closing frame (written at current address, counted), then counter clears.
- `frame_done` held high several cycles: only rising edge (registered previous value) closes a frame.
- `err_overflow` cleared only by reset; `err_short` updated at every frame close.
- Count saturates; `wr_cnt` never exceeds FRAME_PIX, address never wraps.

## Timing
- All outputs registered. Input pixel at edge n → `mem_we`/`mem_addr`/`mem_data` valid after edge n+1 (1-cycle latency), held one cycle.
- `frame_ready`, `frame_pixels`, `err_short` update after edge following the `frame_done` rising edge; `frame_ready` high exactly one cycle.
- Reset (`rst`=0 at a rising edge, any state, mid-frame included): state IDLE, `mem_addr`=0, `mem_data`=0, `mem_we`=0, `frame_ready`=0, `frame_pixels`=0, `err_overflow`=0, `err_short`=0, `busy`=0, `wr_cnt`=0.
- `busy`=1 one cycle after entering CAPTURE, 0 one cycle after leaving.

## Test plan
- Reset mid-CAPTURE with `wr_cnt`=57 → next cycle all outputs at reset values, state IDLE; pixels ignored until re-sync.
- Enable, pulse `frame_done`, stream 19200 valid pixels (160x120) with gaps, pulse `frame_done` → addresses 0..19199 each written once, `pixel_data`=24'h00FF_E0 (B=0x00,G=0xFF,R=0xE0) gives `mem_data`=8'hFC, `frame_ready` one pulse, `frame_pixels`=19200, errors 0.
- Pixels before first `frame_done` after enable → `mem_we` stays 0; first post-sync pixel at address 0.
- 19205 pixels in one frame → 19200 writes, 5 dropped, `err_overflow`=1 persists across next good frame; `frame_ready` pulses.
- 100 pixels then `frame_done` coincident with pixel 101 → 101 writes (addr 100 last), `frame_pixels`=101, `err_short`=1, no `frame_ready`; next full frame clears `err_short`.
- `enable` dropped mid-frame then raised → IDLE, no writes, waits for `frame_done`, restarts at address 0; `frame_done` held 3 cycles closes one frame only.
